// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive engine: FSM encoding,
// push_data_o field positions, data-width encodings and the vote helper.
`timescale 1ns/1ps
package uart_rx_pkg;

  // Receive FSM states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_PUSH      = 3'd5,
    ST_WAIT_HIGH = 3'd6
  } rx_state_e;

  // Field positions inside push_data_o = {data[7:0], parity_err, framing_err, break}
  localparam int DATA_MSB = 10;
  localparam int DATA_LSB = 3;
  localparam int PE       = 2;
  localparam int FE       = 1;
  localparam int BI       = 0;

  // data_bits encodings (character width = data_bits + 5)
  localparam logic [1:0] BITS_5 = 2'd0;
  localparam logic [1:0] BITS_6 = 2'd1;
  localparam logic [1:0] BITS_7 = 2'd2;
  localparam logic [1:0] BITS_8 = 2'd3;

  // Two-out-of-three majority
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync_vote.sv
// Brings the asynchronous serial line into the clk domain and produces the
// 3-sample majority bit around the middle of each bit period.
`timescale 1ns/1ps
module uart_rx_sync_vote
  import uart_rx_pkg::*;
#(
  parameter int OVS   = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             wb_rst_i,
  input  logic             enable,
  input  logic             srx_pad_i,
  input  logic [CNT_W-1:0] cnt,
  output logic             rxs,
  output logic             vote_bit,
  output logic             vote_pt
);

  logic sync_q1, sync_q2;
  logic samp_a, samp_b;

  // Two-flop synchroniser; idle line level is 1
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= srx_pad_i;
      sync_q2 <= sync_q1;
    end
  end

  assign rxs = sync_q2;

  // Capture the first two of the three mid-bit samples
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else if (enable) begin
      if (cnt == CNT_W'(OVS/2 + 1)) samp_a <= rxs;
      if (cnt == CNT_W'(OVS/2))     samp_b <= rxs;
    end
  end

  // Third sample is the live line; the decision is made on this tick
  always_comb begin
    vote_pt  = enable && (cnt == CNT_W'(OVS/2 - 1));
    vote_bit = maj3(samp_a, samp_b, rxs);
  end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: start detection, majority-voted bit sampling,
// 5-8 data bits, optional parity, break detection, push to an external
// RX FIFO and character timeout.
// Push interface: push_o is a one-clk strobe qualified by push_ready_i
// sampled in the PUSH state; when not ready the character is dropped and
// overrun_o pulses instead. push_data_o is stable while push_o is high.
`timescale 1ns/1ps
module uart_rx_engine
  import uart_rx_pkg::*;
#(
  parameter int OVS      = 16,
  parameter int CNT_W    = 5,
  parameter int TO_CHARS = 4,
  parameter int TO_W     = 12
) (
  input  logic        clk,
  input  logic        wb_rst_i,
  input  logic        enable,
  input  logic        rx_reset,
  input  logic        srx_pad_i,
  input  logic [1:0]  data_bits,
  input  logic        parity_en,
  input  logic        even_par,
  input  logic        stick_par,
  input  logic        push_ready_i,
  input  logic        fifo_pop_i,
  input  logic        fifo_empty_i,
  output logic        push_o,
  output logic [10:0] push_data_o,
  output logic        overrun_o,
  output logic        timeout_o,
  output logic        rx_busy_o
);

  localparam logic [TO_W-1:0] TO_UNIT = TO_W'(TO_CHARS * OVS);

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bitcnt_q;
  logic [7:0]       shift_q, shift_in;
  logic             par_q, pe_q;
  logic             rxs, vote_bit, vote_pt, bit_end;
  logic [3:0]       char_bits;
  logic [TO_W-1:0]  to_reload, to_cnt_q, to_eff;
  logic             to_fresh_q;

  uart_rx_sync_vote #(.OVS(OVS), .CNT_W(CNT_W)) u_sync_vote (
    .clk       (clk),
    .wb_rst_i  (wb_rst_i),
    .enable    (enable),
    .srx_pad_i (srx_pad_i),
    .cnt       (cnt_q),
    .rxs       (rxs),
    .vote_bit  (vote_bit),
    .vote_pt   (vote_pt)
  );

  // Last oversample tick of the current bit; voted bit placed at the top of the active width
  always_comb begin
    bit_end  = enable && (cnt_q == '0);
    shift_in = shift_q >> 1;
    shift_in[{1'b1, data_bits}] = vote_bit;
  end

  // FSM state register
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (enable && !rxs) state_d = ST_START;
      ST_START:     if (vote_pt && vote_bit) state_d = ST_IDLE;
                    else if (bit_end) state_d = ST_DATA;
      ST_DATA:      if (bit_end && bitcnt_q == '0) state_d = parity_en ? ST_PARITY : ST_STOP;
      ST_PARITY:    if (bit_end) state_d = ST_STOP;
      ST_STOP:      if (vote_pt) state_d = ST_PUSH;
      ST_PUSH:      state_d = push_data_o[FE] ? ST_WAIT_HIGH : ST_IDLE;
      ST_WAIT_HIGH: if (enable && rxs) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    if (rx_reset) state_d = ST_IDLE;
  end

  assign rx_busy_o = (state_q != ST_IDLE);

  // Bit timing, character assembly, status and push strobes
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_q       <= CNT_W'(OVS - 1);
      bitcnt_q    <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      pe_q        <= 1'b0;
      push_data_o <= '0;
      push_o      <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      push_o    <= 1'b0;
      overrun_o <= 1'b0;
      if (rx_reset) begin
        cnt_q    <= CNT_W'(OVS - 1);
        bitcnt_q <= '0;
        shift_q  <= '0;
      end else begin
        if (state_q == ST_IDLE || state_q == ST_PUSH || state_q == ST_WAIT_HIGH)
          cnt_q <= CNT_W'(OVS - 1);
        else if (enable)
          cnt_q <= (cnt_q == '0) ? CNT_W'(OVS - 1) : cnt_q - 1'b1;
        case (state_q)
          ST_START: if (bit_end) begin
            bitcnt_q <= {1'b1, data_bits};
            shift_q  <= '0;
            par_q    <= 1'b0;
            pe_q     <= 1'b0;
          end
          ST_DATA: begin
            if (vote_pt) shift_q <= shift_in;
            if (bit_end && bitcnt_q != '0) bitcnt_q <= bitcnt_q - 1'b1;
          end
          ST_PARITY: begin
            if (vote_pt) par_q <= vote_bit;
            if (bit_end)
              pe_q <= stick_par ? (par_q == even_par) : ((^shift_q ^ par_q) == even_par);
          end
          ST_STOP: if (vote_pt)
            push_data_o <= {shift_q, pe_q, ~vote_bit,
                            ~vote_bit & (shift_q == 8'd0) & ~(parity_en & par_q)};
          ST_PUSH: begin
            push_o    <= push_ready_i;
            overrun_o <= ~push_ready_i;
          end
          default: ;
        endcase
      end
    end
  end

  // Timeout reload is one full character time (start+data+parity+stop) times TO_CHARS
  always_comb begin
    char_bits = 4'(data_bits) + 4'd7 + 4'(parity_en);
    to_reload = TO_UNIT * TO_W'(char_bits);
    to_eff    = to_fresh_q ? to_reload : to_cnt_q;
    timeout_o = (to_eff == '0) && !fifo_empty_i;
  end

  // Timeout counter; right after reset it reads as the reload value
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      to_cnt_q   <= '0;
      to_fresh_q <= 1'b1;
    end else begin
      to_fresh_q <= 1'b0;
      if (push_o || fifo_pop_i || fifo_empty_i || rx_reset)
        to_cnt_q <= to_reload;
      else if (enable && to_eff != '0)
        to_cnt_q <= to_eff - 1'b1;
      else
        to_cnt_q <= to_eff;
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed and randomized bench for uart_rx_engine with a frame-level
// reference model and an expected-character queue.
`timescale 1ns/1ps
module tb_uart_rx_engine;

  localparam int OVS      = 16;
  localparam int CNT_W    = 5;
  localparam int TO_CHARS = 4;
  localparam int TO_W     = 12;

  logic        clk, wb_rst_i, enable, rx_reset, srx_pad_i;
  logic [1:0]  data_bits;
  logic        parity_en, even_par, stick_par;
  logic        push_ready_i, fifo_pop_i, fifo_empty_i;
  logic        push_o, overrun_o, timeout_o, rx_busy_o;
  logic [10:0] push_data_o;

  int          n_cmp = 0;
  int          n_fail = 0;
  longint      cyc = 0;
  longint      last_push_cyc = 0;
  int          ovr_cycles = 0;
  int          en_div = 1;
  logic [10:0] exp_q[$];
  logic [10:0] got_q[$];

  uart_rx_engine #(.OVS(OVS), .CNT_W(CNT_W), .TO_CHARS(TO_CHARS), .TO_W(TO_W)) dut (
    .clk          (clk),
    .wb_rst_i     (wb_rst_i),
    .enable       (enable),
    .rx_reset     (rx_reset),
    .srx_pad_i    (srx_pad_i),
    .data_bits    (data_bits),
    .parity_en    (parity_en),
    .even_par     (even_par),
    .stick_par    (stick_par),
    .push_ready_i (push_ready_i),
    .fifo_pop_i   (fifo_pop_i),
    .fifo_empty_i (fifo_empty_i),
    .push_o       (push_o),
    .push_data_o  (push_data_o),
    .overrun_o    (overrun_o),
    .timeout_o    (timeout_o),
    .rx_busy_o    (rx_busy_o)
  );

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Oversample tick: one clk out of every en_div
  initial begin
    int ph;
    ph = 0;
    enable = 1'b0;
    forever begin
      @(negedge clk);
      ph++;
      enable = ((ph % en_div) == 0);
    end
  end

  // Output monitor: collects pushed characters and overrun cycles
  initial forever begin
    @(negedge clk);
    if (push_o === 1'b1) begin
      got_q.push_back(push_data_o);
      last_push_cyc = cyc;
    end
    if (overrun_o === 1'b1) ovr_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: what the receiver must report for a frame on the wire
  function automatic logic [10:0] model_char(input logic [7:0] d, input int nb, input bit pen,
                                             input bit even, input bit stick, input bit pbit,
                                             input bit stop);
    logic [7:0] dm;
    bit ones_odd, want_par, pe, fe, bi;
    dm = 8'd0;
    for (int i = 0; i < nb; i++) dm[i] = d[i];
    ones_odd = ^dm;
    if (stick)     want_par = !even;
    else if (even) want_par = ones_odd;
    else           want_par = !ones_odd;
    pe = pen && (pbit != want_par);
    fe = !stop;
    bi = fe && (dm == 8'd0) && (!pen || !pbit);
    return {dm, pe, fe, bi};
  endfunction

  function automatic bit good_parity(input logic [7:0] d, input int nb, input bit even, input bit stick);
    int ones;
    ones = 0;
    for (int i = 0; i < nb; i++) ones += d[i];
    if (stick) return !even;
    return even ? (ones % 2 == 1) : (ones % 2 == 0);
  endfunction

  // Drive one frame: start, data LSB first, optional parity, one stop, then two idle bit times
  task automatic send_frame(input logic [7:0] d, input int nb, input bit pen, input bit pbit,
                            input bit stop, output longint start_cyc);
    bit bq[$];
    bq.push_back(1'b0);
    for (int i = 0; i < nb; i++) bq.push_back(d[i]);
    if (pen) bq.push_back(pbit);
    bq.push_back(stop);
    start_cyc = cyc;
    foreach (bq[i]) begin
      srx_pad_i = bq[i];
      repeat (OVS * en_div) @(negedge clk);
    end
    srx_pad_i = 1'b1;
    repeat (2 * OVS * en_div) @(negedge clk);
  endtask

  // Frame with the current configuration, with its expectation queued first
  task automatic send_expect(input logic [7:0] d, input bit pbit, input bit stop, output longint start_cyc);
    int nb;
    nb = int'(data_bits) + 5;
    exp_q.push_back(model_char(d, nb, parity_en, even_par, stick_par, pbit, stop));
    send_frame(d, nb, parity_en, pbit, stop, start_cyc);
  endtask

  // Compare everything received against everything expected
  task automatic drain_check(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_data"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    longint t0;
    int     k;
    logic [7:0] d;
    bit     pb, st;

    wb_rst_i = 1'b1; rx_reset = 1'b0; srx_pad_i = 1'b1;
    data_bits = 2'd3; parity_en = 1'b0; even_par = 1'b0; stick_par = 1'b0;
    push_ready_i = 1'b1; fifo_pop_i = 1'b0; fifo_empty_i = 1'b1;
    repeat (3) @(negedge clk);
    wb_rst_i = 1'b0;
    @(negedge clk);
    check("rst_push", push_o, 0);
    check("rst_push_data", push_data_o, 0);
    check("rst_overrun", overrun_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_busy", rx_busy_o, 0);
    repeat (5) @(negedge clk);

    // 8N1 0xA5: push about 10 bit times after the start edge
    send_expect(8'hA5, 1'b0, 1'b1, t0);
    check("a5_latency_window", (last_push_cyc - t0 >= 9 * OVS) && (last_push_cyc - t0 <= 10 * OVS), 1);
    check("a5_value", exp_q.size() == 1 ? 32'(exp_q[0]) : 0, {8'hA5, 3'b000});
    drain_check("a5");

    // 7E1 0x41 with the parity bit inverted
    data_bits = 2'd2; parity_en = 1'b1; even_par = 1'b1;
    send_expect(8'h41, !good_parity(8'h41, 7, 1'b1, 1'b0), 1'b1, t0);
    drain_check("7e1_bad_par");

    // Short low glitch on an idle line is a false start
    data_bits = 2'd3; parity_en = 1'b0; even_par = 1'b0;
    srx_pad_i = 1'b0;
    repeat (6) @(negedge clk);
    srx_pad_i = 1'b1;
    check("glitch_busy", rx_busy_o, 1);
    k = 0;
    while (rx_busy_o !== 1'b0 && k < 4 * OVS) begin
      @(negedge clk);
      k++;
    end
    check("glitch_busy_fall", (k <= OVS / 2 + 2), 1);
    repeat (3 * OVS) @(negedge clk);
    check("glitch_no_push", got_q.size(), 0);

    // Break: line low for three character times gives exactly one character
    exp_q.push_back(model_char(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    srx_pad_i = 1'b0;
    repeat (3 * 10 * OVS) @(negedge clk);
    check("break_wait_high", rx_busy_o, 1);
    srx_pad_i = 1'b1;
    repeat (2 * OVS) @(negedge clk);
    check("break_idle", rx_busy_o, 0);
    drain_check("break");

    // FIFO not ready: one-clk overrun, nothing pushed
    push_ready_i = 1'b0;
    ovr_cycles = 0;
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, t0);
    check("overrun_pulse", ovr_cycles, 1);
    check("overrun_no_push", got_q.size(), 0);
    push_ready_i = 1'b1;

    // rx_reset mid-character discards it
    srx_pad_i = 1'b0;
    repeat (OVS) @(negedge clk);
    srx_pad_i = 1'b1;
    repeat (3 * OVS) @(negedge clk);
    check("rxrst_busy_before", rx_busy_o, 1);
    rx_reset = 1'b1;
    @(negedge clk);
    rx_reset = 1'b0;
    check("rxrst_busy_after", rx_busy_o, 0);
    repeat (12 * OVS) @(negedge clk);
    check("rxrst_no_push", got_q.size(), 0);

    // Randomized frames across widths, parity modes and tick rates
    for (int n = 0; n < 12; n++) begin
      en_div    = $urandom_range(1, 3);
      data_bits = 2'($urandom_range(0, 3));
      parity_en = 1'($urandom_range(0, 1));
      even_par  = 1'($urandom_range(0, 1));
      stick_par = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      if ($urandom_range(0, 4) == 0) d = 8'h00;
      pb = good_parity(d, int'(data_bits) + 5, even_par, stick_par);
      if ($urandom_range(0, 3) == 0) pb = !pb;
      st = ($urandom_range(0, 5) != 0);
      send_expect(d, pb, st, t0);
      drain_check("rand");
    end

    // Timeout: 8N1, no pops, counts from the push-cycle reload
    en_div = 1; data_bits = 2'd3; parity_en = 1'b0; even_par = 1'b0; stick_par = 1'b0;
    repeat (4) @(negedge clk);
    fifo_empty_i = 1'b0;
    send_expect(8'h5A, 1'b0, 1'b1, t0);
    drain_check("to_char");
    k = 0;
    while (timeout_o !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("timeout_seen", timeout_o, 1);
    // one edge to reload on push_o, then TO_CHARS*OVS*10 enable ticks
    check("timeout_delay", 32'(cyc - last_push_cyc), 1 + TO_CHARS * OVS * 10);
    fifo_pop_i = 1'b1;
    @(negedge clk);
    fifo_pop_i = 1'b0;
    check("timeout_pop_clear", timeout_o, 0);
    repeat (20) @(negedge clk);
    check("timeout_stays_clear", timeout_o, 0);
    fifo_empty_i = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Hard stop if the directed sequence ever stalls
  initial begin
    #5ms;
    $display("FAIL watchdog: observed no completion expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
